// File: rtl/sparse_select_array_pkg.sv
`default_nettype none
// ============================================================================
// sparse_sel_pkg : default geometry, output slice offset helper, index-bank FSM enum
// Rev 1.0
// ============================================================================
package sparse_sel_pkg;

  localparam int DEF_LANES  = 64;
  localparam int DEF_FANOUT = 16;
  localparam int DEF_GROUPS = 14;
  localparam int DEF_K      = 16;
  localparam int DEF_S      = 8;
  localparam int DEF_ACT_W  = 4;

  typedef enum logic [0:0] {
    IDX_IDLE = 1'b0,
    IDX_PEND = 1'b1
  } idx_state_t;

  // Bit offset of (lane, group, slot) inside the flattened compacted output.
  function automatic int slice_off(input int lane, input int group, input int slot,
                                   input int groups, input int slots, input int width);
    return ((lane * groups + group) * slots + slot) * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sparse_select_array_if.sv
`default_nettype none
// ============================================================================
// sparse_select_array_if : window input / compacted output handshake bundle
// Rev 1.0  (out_cnt present only with SPARSE_SEL_CNT_EN)
// ============================================================================
interface sparse_select_array_if
  import sparse_sel_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int GROUPS = DEF_GROUPS,
  parameter int K      = DEF_K,
  parameter int S      = DEF_S,
  parameter int ACT_W  = DEF_ACT_W
);

  logic                                in_valid;
  logic                                in_ready;
  logic [GROUPS*K*ACT_W-1:0]           in_act;
  logic                                out_valid;
  logic                                out_ready;
  logic [LANES*GROUPS*S*ACT_W-1:0]     out_act;
`ifdef SPARSE_SEL_CNT_EN
  localparam int CNT_W = $clog2(S + 1);
  logic [LANES*GROUPS*CNT_W-1:0]       out_cnt;
`endif

  modport master (
    output in_valid, in_act, out_ready,
    input  in_ready, out_valid, out_act
`ifdef SPARSE_SEL_CNT_EN
    , input out_cnt
`endif
  );

  modport slave (
    input  in_valid, in_act, out_ready,
    output in_ready, out_valid, out_act
`ifdef SPARSE_SEL_CNT_EN
    , output out_cnt
`endif
  );

endinterface
`default_nettype wire

// File: rtl/sparse_select_array_compact.sv
`default_nettype none
// ============================================================================
// sparse_compact : one lane/group, packs masked activations into S slots (comb.)
// Rev 1.0  (cnt port present only with SPARSE_SEL_CNT_EN)
// ============================================================================
module sparse_compact
  import sparse_sel_pkg::*;
#(
  parameter int K     = DEF_K,
  parameter int S     = DEF_S,
  parameter int ACT_W = DEF_ACT_W
) (
  input  logic [K-1:0]           mask,
  input  logic [K*ACT_W-1:0]     act,
  output logic [S*ACT_W-1:0]     slots
`ifdef SPARSE_SEL_CNT_EN
  , output logic [$clog2(S+1)-1:0] cnt
`endif
);

  localparam int PW = $clog2(K + 1);

  logic [PW-1:0] w_pos [K];
  logic [PW-1:0] w_total;

  // w_pos[k] is the slot element k lands in if selected (set bits below k).
  always_comb begin
    w_total = '0;
    for (int k = 0; k < K; k++) begin
      w_pos[k] = w_total;
      w_total  = w_total + PW'(mask[k]);
    end
  end

  // Positions >= S never match a slot, which drops the excess high-index bits.
  always_comb begin
    slots = '0;
    for (int s = 0; s < S; s++) begin
      for (int k = 0; k < K; k++) begin
        if (mask[k] && (w_pos[k] == PW'(s))) begin
          slots[s*ACT_W +: ACT_W] = act[k*ACT_W +: ACT_W];
        end
      end
    end
  end

`ifdef SPARSE_SEL_CNT_EN
  localparam int CW = $clog2(S + 1);
  assign cnt = (w_total > PW'(S)) ? CW'(S) : CW'(w_total);
`endif

endmodule
`default_nettype wire

// File: rtl/sparse_select_array.sv
`default_nettype none
// ============================================================================
// sparse_select_array : 2-stage per-lane sparse activation selector, double-banked masks
// Rev 1.0  (define SPARSE_SEL_CNT_EN to add the per-lane/group out_cnt output)
// ============================================================================
module sparse_select_array
  import sparse_sel_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int FANOUT = DEF_FANOUT,
  parameter int GROUPS = DEF_GROUPS,
  parameter int K      = DEF_K,
  parameter int S      = DEF_S,
  parameter int ACT_W  = DEF_ACT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  sparse_select_array_if.slave   bus,
  input  logic                   flush,
  input  logic                   idx_wr,
  input  logic [LANES*K-1:0]     idx_data,
  input  logic                   idx_commit,
  output logic [LANES-1:0]       ovf
);

  localparam int COPIES = LANES / FANOUT;
  localparam int WIN_W  = GROUPS * K * ACT_W;
  localparam int OUT_W  = LANES * GROUPS * S * ACT_W;
`ifdef SPARSE_SEL_CNT_EN
  localparam int CNT_W  = $clog2(S + 1);
`endif

  idx_state_t               r_state;
  logic                     r_s1_valid;
  logic [WIN_W-1:0]         r_win_s1 [COPIES];
  logic                     r_out_valid;
  logic [OUT_W-1:0]         r_out_act;
  logic [LANES*K-1:0]       r_shadow;
  logic [LANES*K-1:0]       r_active;
  logic [LANES-1:0]         r_ovf;

  logic                     w_adv;
  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_empty;
  logic                     w_copy;
  logic [LANES-1:0]         w_over;
  logic [OUT_W-1:0]         w_compact;

`ifdef SPARSE_SEL_CNT_EN
  logic [LANES*GROUPS*CNT_W-1:0] r_out_cnt;
  logic [LANES*GROUPS*CNT_W-1:0] w_cnt;
  assign bus.out_cnt = r_out_cnt;
`endif

  assign w_adv      = !r_out_valid || bus.out_ready;
  assign w_in_ready = w_adv && (r_state != IDX_PEND) && !flush;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_empty    = !r_s1_valid && !r_out_valid;

  // An idle commit also defers when a window is being accepted on the same
  // edge, so that window is compacted with the bank it was accepted under.
  assign w_copy = w_empty && ((r_state == IDX_PEND) || (idx_commit && !w_accept));

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_act   = r_out_act;
  assign ovf           = r_ovf;

  for (genvar m = 0; m < LANES; m++) begin : g_lane
    assign w_over[m] = ($countones(r_shadow[m*K +: K]) > S);

    for (genvar g = 0; g < GROUPS; g++) begin : g_group
      sparse_compact #(
        .K     (K),
        .S     (S),
        .ACT_W (ACT_W)
      ) u_compact (
        .mask  (r_active[m*K +: K]),
        .act   (r_win_s1[m / FANOUT][g*K*ACT_W +: K*ACT_W]),
        .slots (w_compact[slice_off(m, g, 0, GROUPS, S, ACT_W) +: S*ACT_W])
`ifdef SPARSE_SEL_CNT_EN
        , .cnt (w_cnt[(m*GROUPS + g)*CNT_W +: CNT_W])
`endif
      );
    end
  end

  // Window copies carry no control meaning, so they are left unreset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int c = 0; c < COPIES; c++) begin
        r_win_s1[c] <= bus.in_act;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_act   <= '0;
`ifdef SPARSE_SEL_CNT_EN
      r_out_cnt   <= '0;
`endif
      r_state     <= IDX_IDLE;
      r_shadow    <= '0;
      r_active    <= '0;
      r_ovf       <= '0;
    end else begin
      if (flush) begin
        r_s1_valid  <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (w_adv) begin
        r_s1_valid  <= w_accept;
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_act <= w_compact;
`ifdef SPARSE_SEL_CNT_EN
          r_out_cnt <= w_cnt;
`endif
        end
      end

      if (w_copy) begin
        r_active <= r_shadow;
        r_ovf    <= r_ovf | w_over;
      end
      // Non-blocking update lets a same-edge copy take the pre-write shadow.
      if (idx_wr) begin
        r_shadow <= idx_data;
      end

      case (r_state)
        IDX_IDLE: if (idx_commit && !w_copy) r_state <= IDX_PEND;
        IDX_PEND: if (w_copy)                r_state <= IDX_IDLE;
        default:                             r_state <= IDX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sparse_select_array.sv
`default_nettype none
// ============================================================================
// tb_sparse_select_array : randomized + directed bench against a behavioural model
// Rev 1.0
// ============================================================================
module tb_sparse_select_array;
  import sparse_sel_pkg::*;

  localparam int LANES  = 8;
  localparam int FANOUT = 4;
  localparam int GROUPS = 3;
  localparam int K      = 16;
  localparam int S      = 8;
  localparam int ACT_W  = 4;
  localparam int IN_W   = GROUPS * K * ACT_W;
  localparam int OUT_W  = LANES * GROUPS * S * ACT_W;
`ifdef SPARSE_SEL_CNT_EN
  localparam int CNT_W  = $clog2(S + 1);
  localparam int CNT_T  = LANES * GROUPS * CNT_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic idx_wr = 1'b0;
  logic idx_commit = 1'b0;
  logic [LANES*K-1:0] idx_data = '0;
  logic [LANES-1:0]   ovf;

  sparse_select_array_if #(.LANES(LANES), .GROUPS(GROUPS), .K(K), .S(S), .ACT_W(ACT_W)) bus ();

  sparse_select_array #(
    .LANES(LANES), .FANOUT(FANOUT), .GROUPS(GROUPS), .K(K), .S(S), .ACT_W(ACT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .idx_wr     (idx_wr),
    .idx_data   (idx_data),
    .idx_commit (idx_commit),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit started  = 1'b0;

  task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Straight reading of the selection rule: walk the mask, fill slots in order.
  function automatic logic [OUT_W-1:0] exp_act(input logic [IN_W-1:0] a, input logic [LANES*K-1:0] bank);
    logic [OUT_W-1:0] o;
    int n;
    o = '0;
    for (int m = 0; m < LANES; m++)
      for (int g = 0; g < GROUPS; g++) begin
        n = 0;
        for (int k = 0; k < K; k++)
          if (bank[m*K + k]) begin
            if (n < S) o[((m*GROUPS + g)*S + n)*ACT_W +: ACT_W] = a[(g*K + k)*ACT_W +: ACT_W];
            n++;
          end
      end
    return o;
  endfunction

`ifdef SPARSE_SEL_CNT_EN
  function automatic logic [CNT_T-1:0] exp_cnt(input logic [LANES*K-1:0] bank);
    logic [CNT_T-1:0] c;
    int n;
    c = '0;
    for (int m = 0; m < LANES; m++) begin
      n = $countones(bank[m*K +: K]);
      if (n > S) n = S;
      for (int g = 0; g < GROUPS; g++) c[(m*GROUPS + g)*CNT_W +: CNT_W] = CNT_W'(n);
    end
    return c;
  endfunction
  logic [CNT_T-1:0] m1_cnt = '0, m2_cnt = '0;
`endif

  function automatic logic [IN_W-1:0] rwin();
    logic [IN_W-1:0] w;
    for (int i = 0; i < IN_W/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [K-1:0] rmask();
    logic [K-1:0] v;
    v = K'($urandom);
    case ($urandom % 4)
      0: v = v & K'($urandom);
      1: v = v & K'($urandom) & K'($urandom);
      default: ;
    endcase
    return v;
  endfunction

  // Behavioural model: two in-flight slots, each result fixed at acceptance.
  logic m1_v = 1'b0, m2_v = 1'b0, pend = 1'b0;
  logic [OUT_W-1:0] m1_res = '0, m2_res = '0;
  logic [LANES*K-1:0] sh_bank = '0, act_bank = '0;
  logic [LANES-1:0] ovf_m = '0;
  bit adv_m, rdy_m, acc_m, empty_m, copy_m;

  always @(posedge clk) begin
    if (rst) begin
      m1_v = 1'b0; m2_v = 1'b0; pend = 1'b0; m2_res = '0;
      sh_bank = '0; act_bank = '0; ovf_m = '0;
`ifdef SPARSE_SEL_CNT_EN
      m2_cnt = '0;
`endif
    end else begin
      adv_m   = !m2_v || bus.out_ready;
      rdy_m   = adv_m && !pend && !flush;
      acc_m   = bus.in_valid && rdy_m;
      empty_m = !m1_v && !m2_v;
      copy_m  = empty_m && (pend || (idx_commit && !acc_m));
      if (flush) begin
        m1_v = 1'b0; m2_v = 1'b0;
      end else if (adv_m) begin
        if (m1_v) begin
          m2_res = m1_res;
`ifdef SPARSE_SEL_CNT_EN
          m2_cnt = m1_cnt;
`endif
        end
        m2_v = m1_v;
        m1_v = acc_m;
        if (acc_m) begin
          m1_res = exp_act(bus.in_act, act_bank);
`ifdef SPARSE_SEL_CNT_EN
          m1_cnt = exp_cnt(act_bank);
`endif
        end
      end
      if (copy_m) begin
        for (int m = 0; m < LANES; m++)
          if ($countones(sh_bank[m*K +: K]) > S) ovf_m[m] = 1'b1;
        act_bank = sh_bank;
      end
      if (idx_wr) sh_bank = idx_data;
      pend = copy_m ? 1'b0 : (pend || idx_commit);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", bus.in_ready, (!m2_v || bus.out_ready) && !pend && !flush);
      chk("out_valid", bus.out_valid, m2_v);
      chk("ovf", ovf, ovf_m);
      if (m2_v) begin
        chk("out_act", bus.out_act, m2_res);
`ifdef SPARSE_SEL_CNT_EN
        chk("out_cnt", bus.out_cnt, m2_cnt);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  logic [IN_W-1:0] w;
  logic [IN_W-1:0] wins [3];
  int idx, emitted, waited;
  bit got;

  initial begin
    bus.in_valid = 1'b0; bus.in_act = '0; bus.out_ready = 1'b1;
    tick();
    started = 1'b1;
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_act", bus.out_act, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", bus.in_ready, 1);

    // Mask 0x00FF everywhere, group 0 elements k+1
    idx_data = {LANES{16'h00FF}}; idx_wr = 1'b1; tick(); idx_wr = 1'b0;
    idx_commit = 1'b1; tick(); idx_commit = 1'b0;
    w = rwin();
    for (int k = 0; k < K; k++) w[k*ACT_W +: ACT_W] = 4'(k + 1);
    bus.in_valid = 1'b1; bus.in_act = w; tick(); bus.in_valid = 1'b0;
    tick();
    chk("lat2_valid", bus.out_valid, 1);
    chk("ff_lane0_g0", bus.out_act[31:0], 32'h87654321);
    chk("ff_lane5_g0", bus.out_act[480 +: 32], 32'h87654321);
    chk("ff_ovf", ovf, 0);

    // Lane 3 full mask overflows; flag survives a later sparse mask
    idx_data = {LANES{16'h00FF}}; idx_data[3*K +: K] = 16'hFFFF;
    idx_wr = 1'b1; tick(); idx_wr = 1'b0;
    idx_commit = 1'b1; tick(); idx_commit = 1'b0;
    chk("ovf_set", ovf, 8'h08);
    w = rwin();
    for (int k = 0; k < K; k++) w[(K + k)*ACT_W +: ACT_W] = 4'(15 - k);
    bus.in_valid = 1'b1; bus.in_act = w; tick(); bus.in_valid = 1'b0;
    tick();
    chk("ovf_lane3_g1", bus.out_act[320 +: 32], 32'h89ABCDEF);
    idx_data[3*K +: K] = 16'h0001;
    idx_wr = 1'b1; tick(); idx_wr = 1'b0;
    idx_commit = 1'b1; tick(); idx_commit = 1'b0;
    chk("ovf_held", ovf, 8'h08);

    // Output stall with three windows offered
    for (int i = 0; i < 3; i++) wins[i] = rwin();
    idx = 0; emitted = 0;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc == 5) bus.out_ready = 1'b1;
      bus.in_valid = (idx < 3);
      bus.in_act   = wins[idx < 3 ? idx : 2];
      #1;
      if (cyc == 3) chk("stall_in_ready", bus.in_ready, 0);
      got = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) emitted++;
      tick();
      if (got) idx++;
    end
    bus.in_valid = 1'b0;
    chk("stall_accepted", idx, 3);
    chk("stall_emitted", emitted, 3);

    // Commit with two windows in flight
    for (int m = 0; m < LANES; m++) idx_data[m*K +: K] = rmask();
    idx_wr = 1'b1; tick(); idx_wr = 1'b0;
    bus.in_valid = 1'b1; bus.in_act = rwin(); tick();
    bus.in_act = rwin(); tick();
    bus.in_valid = 1'b0; idx_commit = 1'b1; tick(); idx_commit = 1'b0;
    chk("pend_blocks", bus.in_ready, 0);
    bus.in_valid = 1'b1; bus.in_act = rwin(); got = 1'b0; waited = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      #1;
      got = bus.in_ready;
      if (!got) waited++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pend_released", got, 1);
    chk("pend_cycles", waited, 2);
    repeat (3) tick();

    // Flush with one window in flight and one offered
    bus.in_valid = 1'b1; bus.in_act = rwin(); tick();
    bus.in_act = rwin(); flush = 1'b1; tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_out", bus.out_valid, 0);
      tick();
    end
    bus.in_valid = 1'b1; bus.in_act = rwin(); tick(); bus.in_valid = 1'b0;
    repeat (3) tick();

    // Randomized traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_valid  = ($urandom % 2) == 0;
      bus.in_act    = rwin();
      bus.out_ready = ($urandom % 4) != 0;
      flush         = ($urandom % 25) == 0;
      idx_wr        = ($urandom % 8) == 0;
      idx_commit    = ($urandom % 12) == 0;
      for (int m = 0; m < LANES; m++) idx_data[m*K +: K] = rmask();
      tick();
    end
    flush = 1'b0; idx_wr = 1'b0; idx_commit = 1'b0;

    // Reset mid-stream
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin bus.in_act = rwin(); tick(); end
    rst = 1'b1; tick();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_out_act", bus.out_act, 0);
    rst = 1'b0; bus.in_valid = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sparse_select_array.md
SPARSE_SELECT_ARRAY -- requirements
Module: sparse_select_array

Interface
REQ-001 Parameter LANES, default 64: number of selector lanes (output channels).
REQ-002 Parameter FANOUT, default 16: lanes served by one replicated window register copy; LANES SHALL be a multiple of FANOUT.
REQ-003 Parameter GROUPS, default 14: activation groups per window.
REQ-004 Parameter K, default 16: candidate activations per group, equal to the mask width.
REQ-005 Parameter S, default 8: maximum kept activations per group per lane.
REQ-006 Parameter ACT_W, default 4: activation width in bits.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 flush  in  1  synchronous pipeline clear; index banks untouched.
REQ-010 in_valid  in  1  window valid.
REQ-011 in_ready  out  1  window accepted when in_valid && in_ready.
REQ-012 in_act  in  GROUPS*K*ACT_W  window; group g element k at bits [(g*K+k)*ACT_W +: ACT_W].
REQ-013 idx_wr  in  1  writes idx_data into the shadow bank.
REQ-014 idx_data  in  LANES*K  per-lane masks; lane m at [m*K +: K].
REQ-015 idx_commit  in  1  requests shadow-to-active bank copy.
REQ-016 out_valid  out  1  result valid.
REQ-017 out_ready  in  1  downstream accepts result.
REQ-018 out_act  out  LANES*GROUPS*S*ACT_W  compacted activations; lane m group g slot s at [((m*GROUPS+g)*S+s)*ACT_W +: ACT_W].
REQ-019 ovf  out  LANES  sticky per-lane flag: active mask has more than S set bits.

Function
REQ-020 Two-stage pipeline: stage 1 registers LANES/FANOUT copies of in_act; stage 2 registers compacted output; latency 2 cycles from acceptance to out_valid with out_ready held high.
REQ-021 Advance enable adv = !out_valid || out_ready; both stages shift only when adv is 1; in_ready = adv && !commit_pend && !flush.
REQ-022 Per lane m, group g: slots filled in ascending k order with activations whose mask bit k is 1; unused slots SHALL be zero.
REQ-023 Mask with more than S set bits: only the S lowest-index set bits kept; ovf[m] set and held until rst.
REQ-024 Stalled output (out_valid && !out_ready) SHALL hold out_act stable.
REQ-025 Index states: IDLE, PEND. idx_commit in IDLE with pipeline empty: copy in same edge, stay IDLE. Otherwise go PEND (commit_pend=1), block input, copy at the first edge where both stages are empty, return to IDLE.
REQ-026 idx_wr and the commit copy in the same cycle: the copy takes the old shadow contents; the write lands afterwards.
REQ-027 flush: clears both stage valids at the next edge, drops any in-flight or concurrently offered window; PEND state preserved and completes once empty.
REQ-028 Every accepted window is compacted with the active bank at the time of its acceptance; no window straddles a commit.

Reset
REQ-029 rst clears stage valids, out_valid=0, out_act=0, ovf=0, both index banks to all-zero, state IDLE; in_ready=1 in the cycle after rst deasserts.
REQ-030 rst mid-transfer discards all in-flight windows without emitting them.

Configuration
REQ-031 Macro SPARSE_SEL_CNT_EN defined: adds output port out_cnt, LANES*GROUPS*$clog2(S+1) bits, giving valid slots per lane/group, registered with out_act, reset 0.
REQ-032 SPARSE_SEL_CNT_EN undefined: port and counting logic absent; all other behaviour identical.

Structure
REQ-033 Shared package sparse_sel_pkg holds the default parameter constants, a slice-offset function, and the index-state enum.
REQ-034 One sub-module sparse_compact (one lane, one group: K-bit mask plus K activations in, S slots out, combinational), instantiated LANES*GROUPS times.

Verification
REQ-035 Mask 0x00FF on all lanes, group0 elements = k+1 -> after 2 cycles, slots 0..7 = 1..8, ovf=0.
REQ-036 Mask 0xFFFF on lane 3 -> slots = elements 0..7, ovf[3]=1 and held after a later mask of 0x0001.
REQ-037 out_ready low for 5 cycles with 3 windows offered -> in_ready drops, no loss, outputs emitted in order with values unchanged.
REQ-038 idx_commit with 2 windows in flight -> in_ready=0 until both emitted; the next window uses the new mask.
REQ-039 flush concurrent with in_valid, one window in flight -> no out_valid afterwards; active bank unchanged.
REQ-040 rst asserted mid-stream -> out_valid=0, ovf=0, out_act=0 next cycle.
